// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared frame layout, FIFO entry layout and deframer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int FRAME_W    = 11;
  localparam int START_BIT  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PARITY_BIT = 9;
  localparam int STOP_BIT   = 10;

  // FIFO entry: {parity_err, frame_err, data[7:0]}
  localparam int ENTRY_W    = 10;
  localparam int ENTRY_FERR = 8;
  localparam int ENTRY_PERR = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PUSH  = 2'd2
  } deframe_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Synchronous FIFO with full/empty flags; a write is accepted when
//            full if a read happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_full_cnt = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_rd;
  logic             w_do_wr;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_full_cnt);
  assign w_do_rd   = i_rd_en && !o_empty;
  assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
  assign o_rd_data = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_rd) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_deframe.sv
`default_nettype none
// ============================================================================
// Module   : uart_deframe
// Brief    : Checks start/stop/parity of received UART frames and queues the
//            tagged data bytes behind a valid/ready handshake.
//            Define UART_DEFRAME_ERR_CNT_EN to add the saturating err_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_deframe
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic               baud_clk,
  input  logic               reset,
  input  logic               recieved_flag,
  input  logic [FRAME_W-1:0] data_parll,
  output logic [7:0]         data_out,
  output logic               parity_err,
  output logic               frame_err,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               overrun,
  input  logic               clear_err
`ifdef UART_DEFRAME_ERR_CNT_EN
  ,
  output logic [15:0]        err_cnt
`endif
);

  deframe_state_t     r_state;
  deframe_state_t     w_state_next;
  logic               r_flag_d;
  logic [FRAME_W-1:0] r_frame;
  logic               r_f_err;
  logic               r_p_err;
  logic               r_overrun;
  logic               w_capture;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_head;

  // flag_d resets high so a flag already asserted at reset release is not a new frame
  assign w_capture = recieved_flag && !r_flag_d;
  assign w_pop     = !w_empty && data_ready;
  assign w_drop    = (w_capture && (r_state != IDLE)) || (w_push && w_full && !w_pop);

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      IDLE:    if (w_capture) w_state_next = CHECK;
      CHECK:   w_state_next = PUSH;
      PUSH: begin
        w_push       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_flag_d  <= 1'b1;
      r_frame   <= '0;
      r_f_err   <= 1'b0;
      r_p_err   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_flag_d <= recieved_flag;
      if ((r_state == IDLE) && w_capture) r_frame <= data_parll;
      if (r_state == CHECK) begin
        r_f_err <= r_frame[START_BIT] | ~r_frame[STOP_BIT];
        r_p_err <= (^r_frame[PARITY_BIT:DATA_LSB]) ^ PARITY_ODD;
      end
      if (w_drop)         r_overrun <= 1'b1;
      else if (clear_err) r_overrun <= 1'b0;
    end
  end

  assign w_wr_entry = {r_p_err, r_f_err, r_frame[DATA_MSB:DATA_LSB]};

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (baud_clk),
    .rst       (reset),
    .i_wr_en   (w_push),
    .i_wr_data (w_wr_entry),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign data_valid = !w_empty;
  assign data_out   = w_empty ? 8'h00 : w_head[7:0];
  assign frame_err  = !w_empty && w_head[ENTRY_FERR];
  assign parity_err = !w_empty && w_head[ENTRY_PERR];
  assign overrun    = r_overrun;

`ifdef UART_DEFRAME_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  logic        w_err_ev;

  assign w_err_ev = w_push && (r_p_err || r_f_err);

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      r_err_cnt <= 16'h0000;
    end else if (w_err_ev) begin
      if (clear_err)                  r_err_cnt <= 16'd1;
      else if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end else if (clear_err) begin
      r_err_cnt <= 16'h0000;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_deframe.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_deframe
// Brief    : Self-checking bench for uart_deframe: directed cases plus random
//            frames against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_deframe;

  localparam int FIFO_DEPTH = 4;
  localparam bit PARITY_ODD = 1'b0;

  logic        baud_clk      = 1'b0;
  logic        reset         = 1'b1;
  logic        recieved_flag = 1'b0;
  logic [10:0] data_parll    = '0;
  logic        data_ready    = 1'b0;
  logic        clear_err     = 1'b0;
  logic [7:0]  data_out;
  logic        parity_err;
  logic        frame_err;
  logic        data_valid;
  logic        overrun;
`ifdef UART_DEFRAME_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  uart_deframe #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .baud_clk      (baud_clk),
    .reset         (reset),
    .recieved_flag (recieved_flag),
    .data_parll    (data_parll),
    .data_out      (data_out),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .overrun       (overrun),
    .clear_err     (clear_err)
`ifdef UART_DEFRAME_ERR_CNT_EN
    ,
    .err_cnt       (err_cnt)
`endif
  );

  always #5 baud_clk = ~baud_clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0]  mq[$];
  bit          m_prev = 1'b1;
  bit          m_ovr  = 1'b0;
  int          m_cnt  = 0;
  bit          pend   = 1'b0;
  int          pend_due;
  logic [9:0]  pend_e;
  int          cyc    = 0;
  bit          m_pop, m_cap, m_busy, m_set, m_err;

  function automatic logic [9:0] exp_entry(input logic [10:0] f);
    int ones;
    bit pe, fe;
    ones = $countones(f[9:1]);
    pe   = (ones % 2) != int'(PARITY_ODD);
    fe   = f[0] || !f[10];
    return {pe, fe, f[8:1]};
  endfunction

  always @(posedge baud_clk) begin
    cyc++;
    if (reset) begin
      mq.delete();
      pend   = 1'b0;
      m_prev = 1'b1;
      m_ovr  = 1'b0;
      m_cnt  = 0;
    end else begin
      m_pop  = (mq.size() != 0) && data_ready;
      m_cap  = recieved_flag && !m_prev;
      m_busy = pend;
      m_set  = m_cap && m_busy;
      m_err  = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (pend && pend_due == cyc) begin
        if (mq.size() < FIFO_DEPTH) mq.push_back(pend_e);
        else m_set = 1'b1;
        m_err = pend_e[9] | pend_e[8];
        pend  = 1'b0;
      end
      if (m_cap && !m_busy) begin
        pend     = 1'b1;
        pend_due = cyc + 2;
        pend_e   = exp_entry(data_parll);
      end
      if (m_set) m_ovr = 1'b1;
      else if (clear_err) m_ovr = 1'b0;
      if (m_err) m_cnt = clear_err ? 1 : ((m_cnt < 16'hFFFF) ? m_cnt + 1 : m_cnt);
      else if (clear_err) m_cnt = 0;
      m_prev = recieved_flag;
    end
  end

  always @(negedge baud_clk) begin
    if (cmp_en) begin
      chk("valid", 16'(data_valid), 16'(mq.size() != 0));
      chk("overrun", 16'(overrun), 16'(m_ovr));
      if (mq.size() != 0) begin
        chk("data_out", 16'(data_out), 16'(mq[0][7:0]));
        chk("parity_err", 16'(parity_err), 16'(mq[0][9]));
        chk("frame_err", 16'(frame_err), 16'(mq[0][8]));
      end
`ifdef UART_DEFRAME_ERR_CNT_EN
      chk("err_cnt", err_cnt, 16'(m_cnt));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par,
                                           input bit bad_stop, input bit bad_start);
    logic par;
    par = (^d) ^ PARITY_ODD ^ bad_par;
    return {~bad_stop, par, d, bad_start};
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic send(input logic [10:0] f, input int hold);
    data_parll    = f;
    recieved_flag = 1'b1;
    wait_neg(hold);
    recieved_flag = 1'b0;
    wait_neg(3);
  endtask

  task automatic pop_chk(input logic [7:0] d, input bit pe, input bit fe);
    chk("head_valid", 16'(data_valid), 16'd1);
    chk("head_data", 16'(data_out), 16'(d));
    chk("head_perr", 16'(parity_err), 16'(pe));
    chk("head_ferr", 16'(frame_err), 16'(fe));
    data_ready = 1'b1;
    wait_neg(1);
    data_ready = 1'b0;
  endtask

  task automatic rstep();
    wait_neg(1);
    data_ready = 1'($urandom_range(0, 1));
    clear_err  = ($urandom_range(0, 31) == 0);
    reset      = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hold, gap;
    wait_neg(1);
    cmp_en = 1'b1;
    chk("rst_valid", 16'(data_valid), 16'd0);
    chk("rst_data", 16'(data_out), 16'h00);
    chk("rst_perr", 16'(parity_err), 16'd0);
    chk("rst_ferr", 16'(frame_err), 16'd0);
    chk("rst_overrun", 16'(overrun), 16'd0);
    reset = 1'b0;
    wait_neg(1);

    // A5 with correct even parity, consumer always ready
    data_ready    = 1'b1;
    data_parll    = 11'b1_0_10100101_0;
    recieved_flag = 1'b1;
    wait_neg(1);
    recieved_flag = 1'b0;
    wait_neg(1);
    chk("a5_latency", 16'(data_valid), 16'd0);
    wait_neg(1);
    chk("a5_valid", 16'(data_valid), 16'd1);
    chk("a5_data", 16'(data_out), 16'hA5);
    chk("a5_perr", 16'(parity_err), 16'd0);
    chk("a5_ferr", 16'(frame_err), 16'd0);
    wait_neg(1);
    chk("a5_popped", 16'(data_valid), 16'd0);

    // parity error and stop-bit error tags
    data_ready = 1'b0;
    send(mk_frame(8'h01, 1'b1, 1'b0, 1'b0), 1);
    send(mk_frame(8'h02, 1'b0, 1'b1, 1'b0), 1);
    pop_chk(8'h01, 1'b1, 1'b0);
    pop_chk(8'h02, 1'b0, 1'b1);
    chk("err_drained", 16'(data_valid), 16'd0);

    // five frames into a four-deep FIFO
    for (int i = 0; i < 5; i++) send(mk_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0), 1);
    chk("ovr_set", 16'(overrun), 16'd1);
    for (int i = 0; i < 4; i++) pop_chk(8'h10 + 8'(i), 1'b0, 1'b0);
    chk("ovr_14_absent", 16'(data_valid), 16'd0);
    clear_err = 1'b1;
    wait_neg(1);
    clear_err = 1'b0;
    chk("ovr_cleared", 16'(overrun), 16'd0);

    // flag held three cycles
    send(mk_frame(8'h3C, 1'b0, 1'b0, 1'b0), 3);
    chk("hold_ovr", 16'(overrun), 16'd0);
    pop_chk(8'h3C, 1'b0, 1'b0);
    chk("hold_single", 16'(data_valid), 16'd0);

    // full FIFO with a pop in the PUSH cycle
    for (int i = 0; i < 4; i++) send(mk_frame(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0), 1);
    data_parll    = mk_frame(8'h24, 1'b0, 1'b0, 1'b0);
    recieved_flag = 1'b1;
    wait_neg(1);
    recieved_flag = 1'b0;
    wait_neg(1);
    data_ready = 1'b1;
    wait_neg(1);
    data_ready = 1'b0;
    chk("fullpop_ovr", 16'(overrun), 16'd0);
    for (int i = 1; i < 5; i++) pop_chk(8'h20 + 8'(i), 1'b0, 1'b0);
    chk("fullpop_cnt4", 16'(data_valid), 16'd0);

    // reset while a frame is in CHECK
    send(mk_frame(8'h30, 1'b0, 1'b0, 1'b0), 1);
    send(mk_frame(8'h31, 1'b0, 1'b0, 1'b0), 1);
    data_parll    = mk_frame(8'h32, 1'b0, 1'b0, 1'b0);
    recieved_flag = 1'b1;
    wait_neg(1);
    reset = 1'b1;
    wait_neg(1);
    chk("rstmid_valid", 16'(data_valid), 16'd0);
    reset = 1'b0;
    wait_neg(4);
    chk("rstmid_nocap", 16'(data_valid), 16'd0);
    recieved_flag = 1'b0;
    wait_neg(1);
    send(mk_frame(8'h33, 1'b0, 1'b0, 1'b0), 1);
    pop_chk(8'h33, 1'b0, 1'b0);
    chk("rstmid_empty", 16'(data_valid), 16'd0);

`ifdef UART_DEFRAME_ERR_CNT_EN
    reset = 1'b1;
    wait_neg(1);
    reset      = 1'b0;
    data_ready = 1'b1;
    send(mk_frame(8'h40, 1'b1, 1'b0, 1'b0), 1);
    send(mk_frame(8'h41, 1'b0, 1'b1, 1'b0), 1);
    send(mk_frame(8'h42, 1'b0, 1'b0, 1'b1), 1);
    chk("errcnt_3", err_cnt, 16'd3);
`endif

    // random frames, error injection, back-pressure and back-to-back arrivals
    for (int n = 0; n < 400; n++) begin
      data_parll    = mk_frame(8'($urandom), ($urandom_range(0, 3) == 0),
                               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      recieved_flag = 1'b1;
      hold = $urandom_range(1, 3);
      gap  = $urandom_range(1, 5);
      repeat (hold) rstep();
      recieved_flag = 1'b0;
      repeat (gap) rstep();
    end
    reset      = 1'b0;
    clear_err  = 1'b0;
    data_ready = 1'b1;
    wait_neg(10);
    chk("final_drained", 16'(data_valid), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
